// File: rtl/sampler_dma_pkg.sv
// Shared types and AXI constants for the sampler DMA read path.
package sampler_dma_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    AR_SEND = 2'd1,
    R_WAIT  = 2'd2
  } state_e;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [2:0]  AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam logic [10:0] AXI_4KB_WORDS  = 11'd1024;

endpackage

// File: rtl/sampler_dma_axi_reader.sv
// AXI4 read master for voice DMA requests: one request at a time, split into
// at most two INCR bursts at the 4 KB boundary, beats streamed out unbuffered.
module sampler_dma_axi_reader
  import sampler_dma_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          dma_req,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] address,
  input  logic [7:0]                    dma_req_len,
  output logic                          busy,
  output logic                          req_dropped,
  output logic                          rd_error,
  output logic [C_M_AXI_DATA_WIDTH-1:0] dma_data,
  output logic                          dma_data_valid,
  output logic                          dma_data_last,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rlast,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  output logic [1:0]                    dbg_state
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam logic [AW-1:0] WORD_MASK = {{(AW-2){1'b1}}, 2'b00};

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; arvalid is never withdrawn and araddr/arlen never change until
  // arready is seen. rready is held high for the whole R_WAIT state, so the
  // read stream has no backpressure.

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      remaining_q, remaining_d;
  logic [10:0]     burst_beats_q, burst_beats_d;
  logic            rd_error_q, rd_error_d;
  logic            req_dropped_q, req_dropped_d;
  logic [DW-1:0]   data_q, data_d;
  logic            data_valid_q, data_valid_d;
  logic            data_last_q, data_last_d;

  logic [10:0]     room;
  logic [7:0]      beats;
  logic [7:0]      remaining_dec;
  logic            accept;

  // Words left before the next 4 KB boundary, 1..1024.
  assign room  = AXI_4KB_WORDS - {1'b0, addr_q[11:2]};
  // room is at most 255 whenever it is the smaller operand.
  assign beats = (room > {3'b000, remaining_q}) ? remaining_q : room[7:0];

  assign remaining_dec = (remaining_q != 8'd0) ? remaining_q - 8'd1 : 8'd0;
  assign accept        = (state_q == IDLE) && dma_req && (dma_req_len != 8'd0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      remaining_q   <= '0;
      burst_beats_q <= '0;
      rd_error_q    <= 1'b0;
      req_dropped_q <= 1'b0;
      data_q        <= '0;
      data_valid_q  <= 1'b0;
      data_last_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      burst_beats_q <= burst_beats_d;
      rd_error_q    <= rd_error_d;
      req_dropped_q <= req_dropped_d;
      data_q        <= data_d;
      data_valid_q  <= data_valid_d;
      data_last_q   <= data_last_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    burst_beats_d = burst_beats_q;
    rd_error_d    = rd_error_q;
    req_dropped_d = dma_req && !accept;
    data_d        = data_q;
    data_valid_d  = 1'b0;
    data_last_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d      = address & WORD_MASK;
          remaining_d = dma_req_len;
          rd_error_d  = 1'b0;
          state_d     = AR_SEND;
        end
      end
      AR_SEND: begin
        if (m_axi_arready) begin
          burst_beats_d = {3'b000, beats};
          state_d       = R_WAIT;
        end
      end
      R_WAIT: begin
        if (m_axi_rvalid) begin
          data_d       = m_axi_rdata;
          data_valid_d = 1'b1;
          data_last_d  = (remaining_q == 8'd1);
          remaining_d  = remaining_dec;
          rd_error_d   = rd_error_q || (m_axi_rresp != AXI_RESP_OKAY);
          // rlast always closes the burst, even if it came early.
          if (m_axi_rlast) begin
            if (remaining_dec == 8'd0) begin
              state_d = IDLE;
            end else begin
              addr_d  = addr_q + {{(AW-13){1'b0}}, burst_beats_q, 2'b00};
              state_d = AR_SEND;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_axi_arvalid  = (state_q == AR_SEND);
    m_axi_araddr   = m_axi_arvalid ? addr_q : '0;
    m_axi_arlen    = m_axi_arvalid ? beats - 8'd1 : 8'd0;
    m_axi_arsize   = m_axi_arvalid ? AXI_SIZE_4B : 3'b000;
    m_axi_arburst  = m_axi_arvalid ? AXI_BURST_INCR : 2'b00;
    m_axi_rready   = (state_q == R_WAIT);
    busy           = (state_q != IDLE);
    req_dropped    = req_dropped_q;
    rd_error       = rd_error_q;
    dma_data       = data_q;
    dma_data_valid = data_valid_q;
    dma_data_last  = data_last_q;
    dbg_state      = state_q;
  end

endmodule

// File: tb/tb_sampler_dma_axi_reader.sv
// Randomized bench for sampler_dma_axi_reader: AXI slave with a hashed memory,
// request-level reference model feeding expected-beat and expected-AR queues.
module tb_sampler_dma_axi_reader;
  import sampler_dma_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        dma_req = 1'b0;
  logic [31:0] address = '0;
  logic [7:0]  dma_req_len = '0;
  logic        busy, req_dropped, rd_error;
  logic [31:0] dma_data;
  logic        dma_data_valid, dma_data_last;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid;
  logic        m_axi_arready = 1'b0;
  logic [31:0] m_axi_rdata = '0;
  logic [1:0]  m_axi_rresp = '0;
  logic        m_axi_rlast = 1'b0;
  logic        m_axi_rvalid = 1'b0;
  logic        m_axi_rready;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  int beats_seen = 0;

  // {err, last, data}
  logic [33:0] exp_q[$];
  // {arlen, araddr}
  logic [39:0] ar_exp_q[$];

  // slave state
  int          ar_wait = 0, ar_max = 0, gap_mode = 0, err_beat = -1, glob_beat = 0;
  logic        r_active = 1'b0, r_hold = 1'b0, gap_tog = 1'b0;
  logic [31:0] r_addr = '0;
  int          r_len = 0, r_idx = 0;

  always #5 clk = ~clk;

  sampler_dma_axi_reader dut (
    .clk(clk), .reset_n(reset_n), .dma_req(dma_req), .address(address),
    .dma_req_len(dma_req_len), .busy(busy), .req_dropped(req_dropped),
    .rd_error(rd_error), .dma_data(dma_data), .dma_data_valid(dma_data_valid),
    .dma_data_last(dma_data_last), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .dbg_state(dbg_state)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234 ^ {a[15:0], a[31:16]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Slave: at each falling edge decide what the next rising edge will transfer.
  task automatic slave_step();
    logic [39:0] h;
    logic skip;
    if (r_active) begin
      skip = 1'b0;
      if (!r_hold) begin
        if (gap_mode == 1) begin
          gap_tog = ~gap_tog;
          skip = gap_tog;
        end else if (gap_mode == 2) begin
          skip = ($urandom_range(0, 2) == 0);
        end
      end
      if (skip) begin
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
      end else begin
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = mem_word(r_addr + 32'(r_idx * 4));
        m_axi_rlast  = (r_idx == r_len - 1);
        m_axi_rresp  = (glob_beat == err_beat) ? 2'b10 : 2'b00;
        if (m_axi_rready) begin
          r_hold = 1'b0;
          r_idx++;
          glob_beat++;
          if (r_idx == r_len) r_active = 1'b0;
        end else begin
          r_hold = 1'b1;
        end
      end
    end else begin
      m_axi_rvalid = 1'b0;
      m_axi_rlast  = 1'b0;
      m_axi_rresp  = 2'b00;
    end

    if (m_axi_arvalid) begin
      if (ar_exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL ar_unexpected araddr=0x%0h arlen=%0d required=no AR", m_axi_araddr, m_axi_arlen);
      end else begin
        h = ar_exp_q[0];
        check("ar_addr", m_axi_araddr, h[31:0]);
        check("ar_len", m_axi_arlen, h[39:32]);
        check("ar_size", m_axi_arsize, 3'b010);
        check("ar_burst", m_axi_arburst, 2'b01);
      end
      if (ar_wait > 0) begin
        m_axi_arready = 1'b0;
        ar_wait--;
      end else begin
        m_axi_arready = 1'b1;
        if (ar_exp_q.size() > 0) void'(ar_exp_q.pop_front());
        r_active = 1'b1;
        r_hold   = 1'b0;
        r_addr   = m_axi_araddr;
        r_len    = int'(m_axi_arlen) + 1;
        r_idx    = 0;
        ar_wait  = $urandom_range(0, ar_max);
      end
    end else begin
      m_axi_arready = 1'b0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    slave_step();
  endtask

  // Reference model: split the request into bursts and list every beat.
  task automatic issue(input logic [31:0] a, input int len, input int ar_first,
                       input int ar_mx, input int gmode, input int eb);
    logic [31:0] wa, base;
    int rem, room, b;
    logic e;
    ar_wait = ar_first; ar_max = ar_mx; gap_mode = gmode;
    err_beat = eb; glob_beat = 0;
    wa = a & 32'hFFFF_FFFC;
    base = wa;
    rem = len;
    while (rem > 0) begin
      room = (4096 - int'(wa % 4096)) / 4;
      b = (rem < room) ? rem : room;
      ar_exp_q.push_back({8'(b - 1), wa});
      wa += 32'(b * 4);
      rem -= b;
    end
    e = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (i == eb) e = 1'b1;
      exp_q.push_back({e, (i == len - 1), mem_word(base + 32'(i * 4))});
    end
    address = a; dma_req_len = 8'(len); dma_req = 1'b1;
    cycle();
    dma_req = 1'b0;
    check("accept_arvalid", m_axi_arvalid, 1);
    check("accept_busy", busy, 1);
    check("accept_rd_error", rd_error, 0);
    check("accept_no_drop", req_dropped, 0);
  endtask

  task automatic wait_done(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (!busy && !r_active && ar_exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      cycle();
    end
    if (!done) begin
      $display("FAIL timeout_%s busy=%0b beats_left=%0d required=transfer complete", tag, busy, exp_q.size());
      checks++;
      failures++;
      exp_q.delete();
      ar_exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_req_dropped"}, req_dropped, 0);
    check({tag, "_rd_error"}, rd_error, 0);
    check({tag, "_dma_data"}, dma_data, 0);
    check({tag, "_dma_valid"}, dma_data_valid, 0);
    check({tag, "_dma_last"}, dma_data_last, 0);
    check({tag, "_arvalid"}, m_axi_arvalid, 0);
    check({tag, "_araddr"}, m_axi_araddr, 0);
    check({tag, "_arlen"}, m_axi_arlen, 0);
    check({tag, "_arsize"}, m_axi_arsize, 0);
    check({tag, "_arburst"}, m_axi_arburst, 0);
    check({tag, "_rready"}, m_axi_rready, 0);
    check({tag, "_state"}, dbg_state, IDLE);
  endtask

  // Monitor: every output beat is checked against the head of the scoreboard.
  always @(negedge clk) begin : monitor
    logic [33:0] e;
    if (dma_data_valid) begin
      beats_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL beat_unexpected data=0x%0h required=no beat", dma_data);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", dma_data, e[31:0]);
        check("beat_last", dma_data_last, e[32]);
        check("beat_rd_error", rd_error, e[33]);
        check("beat_busy", busy, !e[32]);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int b0;
    logic [31:0] r;
    logic [11:0] off;
    int len, eb;

    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    reset_n = 1'b1;
    cycle();

    // aligned 4-beat read
    issue(32'h1000_0000, 4, 0, 0, 0, -1);
    wait_done("aligned4");

    // 64 beats across a 4 KB boundary
    issue(32'h0000_0FC0, 64, 0, 0, 0, -1);
    wait_done("split64");

    // arready held low, rvalid every other cycle
    issue(32'h4000_0200, 16, 10, 2, 1, -1);
    wait_done("slow16");

    // request while busy, then zero-length request while idle
    issue(32'h3000_1000, 16, 3, 1, 2, -1);
    cycle(); cycle();
    address = 32'hDEAD_0000; dma_req_len = 8'd8; dma_req = 1'b1;
    cycle();
    dma_req = 1'b0;
    check("drop_busy_pulse", req_dropped, 1);
    cycle();
    check("drop_busy_clear", req_dropped, 0);
    wait_done("drop16");
    cycle();
    address = 32'h1234_5678; dma_req_len = 8'd0; dma_req = 1'b1;
    cycle();
    dma_req = 1'b0;
    check("drop_zero_pulse", req_dropped, 1);
    check("drop_zero_busy", busy, 0);
    check("drop_zero_arvalid", m_axi_arvalid, 0);
    cycle();
    check("drop_zero_clear", req_dropped, 0);

    // SLVERR on beat 2, then a clean request clears rd_error
    issue(32'h5000_0010, 4, 1, 1, 0, 1);
    wait_done("slverr4");
    check("err_sticky_after", rd_error, 1);
    issue(32'h5000_0100, 8, 0, 1, 2, -1);
    wait_done("clean8");

    // reset during beat 30 of 64
    b0 = beats_seen;
    issue(32'h2000_0100, 64, 0, 0, 0, -1);
    for (int i = 0; i < 1000 && (beats_seen - b0) < 29; i++) cycle();
    check("rst_reached_beat29", (beats_seen - b0) >= 29, 1);
    reset_n = 1'b0;
    cycle();
    check_reset_outputs("midrst");
    exp_q.delete();
    ar_exp_q.delete();
    r_active = 1'b0; r_hold = 1'b0;
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_arready = 1'b0;
    reset_n = 1'b1;
    cycle();
    issue(32'h2000_0400, 4, 0, 0, 0, -1);
    wait_done("post_reset4");

    // randomized requests, biased toward the 4 KB boundary
    for (int t = 0; t < 16; t++) begin
      r = $urandom();
      if ($urandom_range(0, 1) == 1) off = 12'hFFF - 12'($urandom_range(0, 1020));
      else off = 12'($urandom_range(0, 4095));
      len = $urandom_range(1, 255);
      eb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
      issue({r[31:12], off}, len, $urandom_range(0, 4), $urandom_range(0, 3),
            $urandom_range(0, 2), eb);
      wait_done("random");
    end

    repeat (4) cycle();
    check("exp_q_drained", exp_q.size(), 0);
    check("final_idle", dbg_state, IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sampler_dma_axi_reader.md
# sampler_dma_axi_reader

AXI4 read master that services burst requests from the sampler's per-voice DMA request FSMs. It accepts one request at a time (word address plus beat count), issues one or two AXI4 INCR read bursts (split at 4 KB boundaries), and returns each read beat on a valid/last stream with no backpressure. It sits between the voice request FSM and the PS HP/ACP slave port.

## Interface
- C_M_AXI_ADDR_WIDTH, 32, address width
- C_M_AXI_DATA_WIDTH, 32, data width; only 32 is supported
- clk  in  1  clock; single clock domain
- reset_n  in  1  reset, synchronous, active-low
- dma_req  in  1  single-cycle request strobe
- address  in  C_M_AXI_ADDR_WIDTH  start byte address; bits [1:0] ignored (forced 0)
- dma_req_len  in  8  beat count, 1..255; 0 is illegal
- busy  out  1  high from request acceptance until the final beat is output
- req_dropped  out  1  one-cycle pulse when dma_req is rejected
- rd_error  out  1  sticky; any RRESP != OKAY in the current transfer
- dma_data  out  C_M_AXI_DATA_WIDTH  returned read data
- dma_data_valid  out  1  one cycle per beat
- dma_data_last  out  1  high with the final beat of the whole request only
- m_axi_araddr/arlen[7:0]/arsize[2:0]/arburst[1:0]/arvalid  out; m_axi_arready  in
- m_axi_rdata/rresp[1:0]/rlast/rvalid  in; m_axi_rready  out

## Operation
- States: IDLE, AR_SEND, R_WAIT.
- IDLE: if dma_req=1 and dma_req_len≠0:
  - latch addr = {address[31:2],2'b00} and remaining = dma_req_len;
  - clear rd_error, set busy, go to AR_SEND.
- IDLE with dma_req=1 and dma_req_len=0: pulse req_dropped and stay in IDLE.
- dma_req=1 in any state other than IDLE: pulse req_dropped. The request is ignored and the current transfer is unaffected.
- Burst sizing in AR_SEND:
  - room = (4096 − addr[11:0]) >> 2, range 1..1024;
  - beats = min(remaining, room);
  - arlen = beats − 1, arsize = 3'b010, arburst = INCR.
- AR_SEND: arvalid=1. On arvalid & arready, go to R_WAIT with burst_beats = beats.
- R_WAIT: rready=1. On each rvalid & rready handshake:
  - forward rdata;
  - decrement remaining;
  - OR (rresp≠0) into rd_error.
- At the handshake carrying rlast:
  - if remaining after decrement = 0: go to IDLE;
  - else: addr += burst_beats×4, go to AR_SEND (second burst).
- dma_data_last = 1 only on the beat that brings remaining to 0. An rlast that ends the first split burst does not assert dma_data_last.
- If rlast arrives before burst_beats beats have been received, treat it as burst end anyway; remaining reflects the beats actually received.
- If burst_beats beats have been received without rlast, keep waiting for rlast.
- Width rules:
  - remaining is 8 bits; room and beat counters are 11 bits;
  - the address adds with no wrap handling above the 4 KB split.

## Timing
- Reset values, all outputs 0: busy, req_dropped, rd_error, dma_data, dma_data_valid, dma_data_last, arvalid, araddr, arlen, arsize, arburst, rready.
- dma_req sampled at edge N in IDLE:
  - arvalid=1 and busy=1 from N+1.
  - araddr/arlen are stable while arvalid=1 and arready=0.
  - arvalid drops the cycle after the handshake.
- Beat handshake at edge M → dma_data/dma_data_valid registered at M+1. Latency is 1 cycle and there is no buffering.
- The final beat at edge M gives:
  - dma_data_last=1 and busy=0 at M+1;
  - state IDLE at M+1;
  - a new dma_req accepted at M+1 → arvalid at M+2.
- req_dropped is asserted the cycle after the offending dma_req.
- Reset asserted mid-transfer: all outputs take their reset values at the next edge and state returns to IDLE. Reset is system-wide, so the AXI slave is reset together with this block.
- rready is 0 outside R_WAIT. Only one burst is ever outstanding.

## Structure
- Shared package sampler_dma_pkg holds:
  - state enum (IDLE, AR_SEND, R_WAIT);
  - AXI_BURST_INCR = 2'b01, AXI_SIZE_4B = 3'b010, AXI_RESP_OKAY = 2'b00;
  - AXI_4KB_WORDS = 1024.
- No sub-module: one FSM plus datapath registers in a single module.

## Test plan
- Aligned 4-beat read at 0x1000_0000, arready immediate → one AR (arlen=3, arsize=2, arburst=1); 4 dma_data_valid pulses with last on the 4th; busy low the same cycle as last.
- 64-beat read at 0x0000_0FC0:
  - AR1: araddr=0x0FC0, arlen=15;
  - AR2: araddr=0x1000, arlen=47;
  - first rlast not forwarded as last; dma_data_last only on beat 64.
- arready held low 10 cycles, rvalid gapped every other cycle → araddr/arlen stable throughout; 16 beats delivered in order, data matches the memory model.
- dma_req pulsed while busy, plus dma_req_len=0 in IDLE → req_dropped pulses, no extra AR; the in-flight transfer completes intact.
- RRESP=SLVERR on beat 2 of 4 → rd_error=1 from beat 2 onward; all 4 beats forwarded; rd_error cleared on the next accepted request.
- reset_n low for 1 cycle during beat 30 of 64 → all outputs 0 next edge, state IDLE; a subsequent 4-beat request completes normally.
